// File: rtl/vga_draw_arbiter.sv
// Round-robin owner of the VGA adapter pixel port among four drawing engines; the owner holds it until done/abandon/watchdog.
// Pixel path is one registered stage; requests from non-owners wait until the port returns to IDLE.
module vga_draw_arbiter #(
  parameter int TIMEOUT = 20000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  req,
  input  logic [3:0]  done,
  input  logic [31:0] req_x,
  input  logic [27:0] req_y,
  input  logic [11:0] req_colour,
  input  logic [3:0]  req_plot,
  output logic [3:0]  grant,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        timeout_err,
  output logic [1:0]  err_id
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, RELEASE = 2'd2} state_t;

  localparam logic [15:0] CNT_MAX = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  err_id_q, err_id_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  grant_q, grant_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [2:0]  colour_q, colour_d;
  logic        plot_q, plot_d;
  logic        timeout_err_q, timeout_err_d;
  logic [1:0]  win;

  // Descending scan so the smallest offset from ptr wins.
  always_comb begin
    win = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr_q + 2'(i)]) win = ptr_q + 2'(i);
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    err_id_d      = err_id_q;
    cnt_d         = cnt_q;
    grant_d       = grant_q;
    x_d           = x_q;
    y_d           = y_q;
    colour_d      = colour_q;
    plot_d        = 1'b0;
    timeout_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d = win;
          grant_d = 4'b0001 << win;
          cnt_d   = 16'd0;
          state_d = OWN;
        end
      end
      OWN: begin
        x_d      = req_x[{owner_q, 3'b000} +: 8];
        y_d      = req_y[7 * owner_q +: 7];
        colour_d = req_colour[3 * owner_q +: 3];
        plot_d   = req_plot[owner_q];
        cnt_d    = cnt_q + 16'd1;
        if (done[owner_q] || !req[owner_q]) begin
          grant_d = 4'b0000;
          state_d = RELEASE;
        end else if (cnt_q == CNT_MAX) begin
          // Revoked owner's last pixel is suppressed.
          grant_d       = 4'b0000;
          plot_d        = 1'b0;
          timeout_err_d = 1'b1;
          err_id_d      = owner_q;
          state_d       = RELEASE;
        end
      end
      RELEASE: begin
        grant_d = 4'b0000;
        ptr_d   = owner_q + 2'd1;
        state_d = IDLE;
      end
      default: begin
        grant_d = 4'b0000;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      ptr_q         <= 2'd0;
      owner_q       <= 2'd0;
      err_id_q      <= 2'd0;
      cnt_q         <= 16'd0;
      grant_q       <= 4'b0000;
      x_q           <= 8'd0;
      y_q           <= 7'd0;
      colour_q      <= 3'd0;
      plot_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      err_id_q      <= err_id_d;
      cnt_q         <= cnt_d;
      grant_q       <= grant_d;
      x_q           <= x_d;
      y_q           <= y_d;
      colour_q      <= colour_d;
      plot_q        <= plot_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign grant       = grant_q;
  assign x           = x_q;
  assign y           = y_q;
  assign colour      = colour_q;
  assign plot        = plot_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = timeout_err_q;
  assign err_id      = err_id_q;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Directed bench for vga_draw_arbiter with a short watchdog (TIMEOUT=8).
module tb_vga_draw_arbiter;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic [3:0]  done;
  logic [31:0] req_x;
  logic [27:0] req_y;
  logic [11:0] req_colour;
  logic [3:0]  req_plot;
  logic [3:0]  grant;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;
  logic        timeout_err;
  logic [1:0]  err_id;

  int total = 0;
  int bad   = 0;

  vga_draw_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .done(done),
    .req_x(req_x), .req_y(req_y), .req_colour(req_colour), .req_plot(req_plot),
    .grant(grant), .x(x), .y(y), .colour(colour), .plot(plot),
    .busy(busy), .timeout_err(timeout_err), .err_id(err_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_eng(input int i, input logic [7:0] xv, input logic [6:0] yv,
                         input logic [2:0] cv, input logic pv);
    req_x[i*8 +: 8]      = xv;
    req_y[i*7 +: 7]      = yv;
    req_colour[i*3 +: 3] = cv;
    req_plot[i]          = pv;
  endtask

  task automatic quiesce();
    req = 4'b0000; done = 4'b0000; req_plot = 4'b0000;
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    logic [28:0] all_out;
    reset_n = 1'b0; req = 0; done = 0; req_x = 0; req_y = 0; req_colour = 0; req_plot = 0;
    #3;
    all_out = {grant, x, y, colour, plot, busy, timeout_err, err_id};
    total++;
    if (all_out !== 29'd0) begin
      $display("FAIL reset_initial got=%h exp=0", all_out); bad++;
    end
    tick();
    reset_n = 1'b1;
    tick();
    req = 4'b0100;
    set_eng(2, 8'd5, 7'd6, 3'd1, 1'b1);
    tick();
    tick();
    total++;
    if (plot !== 1'b1 || x !== 8'd5 || busy !== 1'b1) begin
      $display("FAIL reset_preown got plot=%b x=%0d busy=%b exp 1 5 1", plot, x, busy); bad++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    all_out = {grant, x, y, colour, plot, busy, timeout_err, err_id};
    total++;
    if (all_out !== 29'd0) begin
      $display("FAIL reset_async got=%h exp=0", all_out); bad++;
    end
    reset_n = 1'b1;
    tick();
    total++;
    if (grant !== 4'b0100) begin
      $display("FAIL reset_regrant got=%b exp=0100", grant); bad++;
    end
    quiesce();
  endtask

  task automatic test_single();
    // ptr is 3 after owner 2 released
    req = 4'b0100;
    set_eng(2, 8'd10, 7'd20, 3'd3, 1'b1);
    set_eng(0, 8'd99, 7'd99, 3'd7, 1'b1);
    tick();
    total++;
    if (grant !== 4'b0100) begin
      $display("FAIL single_grant got=%b exp=0100", grant); bad++;
    end
    tick();
    total++;
    if (x !== 8'd10 || y !== 7'd20 || colour !== 3'd3 || plot !== 1'b1) begin
      $display("FAIL single_pixel got x=%0d y=%0d c=%0d p=%b exp 10 20 3 1", x, y, colour, plot); bad++;
    end
    done = 4'b0100;
    tick();
    total++;
    if (grant !== 4'b0000 || plot !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL single_done got grant=%b plot=%b busy=%b exp 0000 1 1", grant, plot, busy); bad++;
    end
    done = 4'b0000; req = 4'b0000;
    tick();
    total++;
    if (plot !== 1'b0 || busy !== 1'b0 || x !== 8'd10) begin
      $display("FAIL single_idle got plot=%b busy=%b x=%0d exp 0 0 10", plot, busy, x); bad++;
    end
    req_plot = 4'b0000;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [5];
    exp_seq[0] = 4'b1000; exp_seq[1] = 4'b0001; exp_seq[2] = 4'b0010;
    exp_seq[3] = 4'b0100; exp_seq[4] = 4'b1000;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (grant !== exp_seq[k]) begin
        $display("FAIL rr_grant%0d got=%b exp=%b", k, grant, exp_seq[k]); bad++;
      end
      done = exp_seq[k];
      tick();
      done = 4'b0000;
      total++;
      if (grant !== 4'b0000) begin
        $display("FAIL rr_dead1_%0d got=%b exp=0000", k, grant); bad++;
      end
      tick();
      if (k == 4) req = 4'b0000;
      total++;
      if (grant !== 4'b0000) begin
        $display("FAIL rr_dead2_%0d got=%b exp=0000", k, grant); bad++;
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    // ptr is 0 here
    req = 4'b0010;
    set_eng(1, 8'd40, 7'd41, 3'd2, 1'b1);
    tick();
    req = 4'b0011;
    n = 0;
    while (grant === 4'b0010 && n < 20) begin
      n++;
      tick();
    end
    total++;
    if (n != 8) begin
      $display("FAIL to_hold got=%0d cycles exp=8", n); bad++;
    end
    total++;
    if (timeout_err !== 1'b1 || err_id !== 2'd1 || plot !== 1'b0) begin
      $display("FAIL to_pulse got err=%b id=%0d plot=%b exp 1 1 0", timeout_err, err_id, plot); bad++;
    end
    tick();
    total++;
    if (timeout_err !== 1'b0 || err_id !== 2'd1) begin
      $display("FAIL to_pulse_end got err=%b id=%0d exp 0 1", timeout_err, err_id); bad++;
    end
    tick();
    total++;
    if (grant !== 4'b0001) begin
      $display("FAIL to_next got=%b exp=0001", grant); bad++;
    end
    quiesce();
  endtask

  task automatic test_tie();
    // ptr is 1 here
    req = 4'b1000;
    set_eng(3, 8'd7, 7'd8, 3'd5, 1'b1);
    tick();
    for (int k = 0; k < 7; k++) tick();
    done = 4'b1000;
    tick();
    total++;
    if (timeout_err !== 1'b0 || err_id !== 2'd1) begin
      $display("FAIL tie_noerr got err=%b id=%0d exp 0 1", timeout_err, err_id); bad++;
    end
    total++;
    if (plot !== 1'b1 || x !== 8'd7 || grant !== 4'b0000) begin
      $display("FAIL tie_pixel got plot=%b x=%0d grant=%b exp 1 7 0000", plot, x, grant); bad++;
    end
    done = 4'b0000; req = 4'b0000;
    tick();
    total++;
    if (timeout_err !== 1'b0) begin
      $display("FAIL tie_later got err=%b exp 0", timeout_err); bad++;
    end
    quiesce();
  endtask

  task automatic test_abandon();
    // ptr is 0 here
    req = 4'b0011;
    set_eng(0, 8'd33, 7'd34, 3'd6, 1'b1);
    tick();
    total++;
    if (grant !== 4'b0001) begin
      $display("FAIL ab_grant got=%b exp=0001", grant); bad++;
    end
    req = 4'b0010;
    tick();
    total++;
    if (grant !== 4'b0000 || timeout_err !== 1'b0 || plot !== 1'b1 || x !== 8'd33) begin
      $display("FAIL ab_exit got grant=%b err=%b plot=%b x=%0d exp 0000 0 1 33",
               grant, timeout_err, plot, x); bad++;
    end
    tick();
    total++;
    if (grant !== 4'b0000 || plot !== 1'b0) begin
      $display("FAIL ab_dead got grant=%b plot=%b exp 0000 0", grant, plot); bad++;
    end
    tick();
    total++;
    if (grant !== 4'b0010) begin
      $display("FAIL ab_next got=%b exp=0010", grant); bad++;
    end
    quiesce();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_tie();
    test_abandon();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
